// File: rtl/geo_pkg.sv
// Shared geometry types and defaults for the object-motion / collision slice.
package geo_pkg;

  localparam int unsigned CW_DEFAULT       = 65;
  localparam int unsigned GROUND_Y_DEFAULT = 480;
  localparam int unsigned LAND_TOL_DEFAULT = 4;
  localparam int unsigned FLOOR_W          = 10;
  localparam int unsigned ATT_W            = 8;

  typedef logic signed [CW_DEFAULT-1:0] coord_t;

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    DEAD    = 2'd1,
    RESPAWN = 2'd2
  } play_state_t;

endpackage

// File: rtl/aabb_overlap.sv
// Combinational axis-aligned box overlap of two centre/half-size boxes.
// Math is widened by two bits so differences and sums of signed coordinates never wrap.
module aabb_overlap #(
  parameter int unsigned CW = 65
) (
  input  logic signed [CW-1:0] a_x,
  input  logic signed [CW-1:0] a_y,
  input  logic signed [CW-1:0] a_s,
  input  logic signed [CW-1:0] b_x,
  input  logic signed [CW-1:0] b_y,
  input  logic signed [CW-1:0] b_s,
  output logic                 hx,
  output logic                 vy,
  output logic                 overlap
);

  localparam int unsigned W = CW + 2;

  logic signed [W-1:0] dx;
  logic signed [W-1:0] dy;
  logic signed [W-1:0] adx;
  logic signed [W-1:0] ady;
  logic signed [W-1:0] sum_s;

  always_comb begin
    dx    = W'(a_x) - W'(b_x);
    dy    = W'(a_y) - W'(b_y);
    adx   = dx[W-1] ? -dx : dx;
    ady   = dy[W-1] ? -dy : dy;
    sum_s = W'(a_s) + W'(b_s);
  end

  assign hx      = (adx < sum_s);
  assign vy      = (ady < sum_s);
  assign overlap = hx & vy;

endmodule

// File: rtl/collision_ctrl.sv
// Decides the ball's fate each frame: death on spike/side hit, landing row otherwise,
// and sequences PLAY -> DEAD -> RESPAWN while counting attempts.
module collision_ctrl
  import geo_pkg::*;
#(
  parameter int unsigned GROUND_Y     = GROUND_Y_DEFAULT,
  parameter int unsigned LAND_TOL     = LAND_TOL_DEFAULT,
  parameter int unsigned DEATH_FRAMES = 4,
  parameter int unsigned GRACE_FRAMES = 8,
  parameter int unsigned CW           = CW_DEFAULT
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  input  logic signed [CW-1:0] BallX,
  input  logic signed [CW-1:0] BallY,
  input  logic signed [CW-1:0] BallS,
  input  logic signed [CW-1:0] spikeX,
  input  logic signed [CW-1:0] spikeY,
  input  logic signed [CW-1:0] spikeS,
  input  logic signed [CW-1:0] pfX,
  input  logic signed [CW-1:0] pfY,
  input  logic signed [CW-1:0] pfS,
  output logic                 death_reset,
  output logic [FLOOR_W-1:0]   ball_floor,
  output logic [ATT_W-1:0]     attempts,
  output logic [1:0]           play_state
);

  localparam int unsigned W       = CW + 2;
  localparam int unsigned MAX_CNT = (DEATH_FRAMES > GRACE_FRAMES) ? DEATH_FRAMES : GRACE_FRAMES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT) + 1;

  localparam logic [CNT_W-1:0]   DEAD_LAST  = CNT_W'(DEATH_FRAMES - 1);
  localparam logic [CNT_W-1:0]   GRACE_LAST = CNT_W'(GRACE_FRAMES - 1);
  localparam logic signed [W-1:0] TOL_W     = W'(LAND_TOL);
  localparam logic signed [W-1:0] GROUND_W  = W'(GROUND_Y);
  localparam logic [FLOOR_W-1:0] GROUND_F   = FLOOR_W'(GROUND_Y);
  localparam logic [ATT_W-1:0]   ATT_MAX    = '1;

  play_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               death_reset_q, death_reset_d;
  logic [FLOOR_W-1:0] ball_floor_q, ball_floor_d;
  logic [ATT_W-1:0]   attempts_q, attempts_d;

  logic sp_hx, sp_vy, spike_hit;
  logic pf_hx, pf_vy, pf_ov;
  logic unused_ok;

  aabb_overlap #(.CW(CW)) u_ball_spike (
    .a_x(BallX), .a_y(BallY), .a_s(BallS),
    .b_x(spikeX), .b_y(spikeY), .b_s(spikeS),
    .hx(sp_hx), .vy(sp_vy), .overlap(spike_hit)
  );

  aabb_overlap #(.CW(CW)) u_ball_pf (
    .a_x(BallX), .a_y(BallY), .a_s(BallS),
    .b_x(pfX), .b_y(pfY), .b_s(pfS),
    .hx(pf_hx), .vy(pf_vy), .overlap(pf_ov)
  );

  assign unused_ok = ^{sp_hx, sp_vy, pf_vy, pf_ov};

  // Platform contact: landing within tolerance of the top, otherwise a side hit
  logic signed [W-1:0] pf_top, pf_bot, ball_bot, ball_top, land_lim;
  logic                land, side_hit, hit;
  logic [FLOOR_W-1:0]  pf_floor;

  always_comb begin
    pf_top   = W'(pfY) - W'(pfS);
    pf_bot   = W'(pfY) + W'(pfS);
    ball_bot = W'(BallY) + W'(BallS);
    ball_top = W'(BallY) - W'(BallS);
    land_lim = pf_top + TOL_W;
    land     = pf_hx & (ball_bot <= land_lim);
    side_hit = pf_hx & (ball_bot > land_lim) & (ball_top < pf_bot);
    hit      = spike_hit | side_hit;
    if (pf_top < W'(0))         pf_floor = '0;
    else if (pf_top > GROUND_W) pf_floor = GROUND_F;
    else                        pf_floor = FLOOR_W'(pf_top);
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q       <= PLAY;
      cnt_q         <= '0;
      death_reset_q <= 1'b0;
      ball_floor_q  <= GROUND_F;
      attempts_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      death_reset_q <= death_reset_d;
      ball_floor_q  <= ball_floor_d;
      attempts_q    <= attempts_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      PLAY: begin
        if (hit) begin
          state_d = DEAD;
          cnt_d   = '0;
        end
      end
      DEAD: begin
        if (cnt_q == DEAD_LAST) begin
          state_d = RESPAWN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESPAWN: begin
        if (cnt_q == GRACE_LAST) begin
          state_d = PLAY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = PLAY;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: hit wins over landing; only PLAY may lift the floor off the ground
  always_comb begin
    death_reset_d = 1'b0;
    ball_floor_d  = GROUND_F;
    attempts_d    = attempts_q;
    case (state_q)
      PLAY: begin
        if (hit) begin
          death_reset_d = 1'b1;
          attempts_d    = (attempts_q == ATT_MAX) ? attempts_q : attempts_q + ATT_W'(1);
        end else if (land) begin
          ball_floor_d = pf_floor;
        end
      end
      DEAD:    death_reset_d = (cnt_q != DEAD_LAST);
      default: death_reset_d = 1'b0;
    endcase
  end

  assign death_reset = death_reset_q;
  assign ball_floor  = ball_floor_q;
  assign attempts    = attempts_q;
  assign play_state  = state_q;

endmodule

// File: tb/tb_collision_ctrl.sv
// Self-checking bench for collision_ctrl: directed scenarios plus random frames
// against a timeline model (frames elapsed since the last death).
module tb_collision_ctrl;

  localparam int CW   = 65;
  localparam int GY   = 480;
  localparam int TOL  = 4;
  localparam int DF   = 4;
  localparam int GF   = 8;
  localparam int LIVE = DF + GF;

  logic frame_clk;
  logic Reset;
  int bx, by, bs, sx, sy, ss, px, py, ps;

  logic signed [CW-1:0] BallX, BallY, BallS, spikeX, spikeY, spikeS, pfX, pfY, pfS;
  logic        death_reset;
  logic [9:0]  ball_floor;
  logic [7:0]  attempts;
  logic [1:0]  play_state;

  assign BallX  = CW'(bx);
  assign BallY  = CW'(by);
  assign BallS  = CW'(bs);
  assign spikeX = CW'(sx);
  assign spikeY = CW'(sy);
  assign spikeS = CW'(ss);
  assign pfX    = CW'(px);
  assign pfY    = CW'(py);
  assign pfS    = CW'(ps);

  collision_ctrl dut (
    .frame_clk(frame_clk), .Reset(Reset),
    .BallX(BallX), .BallY(BallY), .BallS(BallS),
    .spikeX(spikeX), .spikeY(spikeY), .spikeS(spikeS),
    .pfX(pfX), .pfY(pfY), .pfS(pfS),
    .death_reset(death_reset), .ball_floor(ball_floor),
    .attempts(attempts), .play_state(play_state)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Model: frames since the last death decide the phase; large means alive.
  int since   = LIVE;
  int m_att   = 0;
  int m_floor = GY;

  function automatic longint labs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_edge();
    longint pf_top, bot, lim;
    bit sp_hit, hxp, land, side, hit, alive;
    if (Reset) begin
      since = LIVE; m_att = 0; m_floor = GY;
      return;
    end
    sp_hit = (labs(longint'(bx) - sx) < bs + ss) && (labs(longint'(by) - sy) < bs + ss);
    hxp    = labs(longint'(bx) - px) < bs + ps;
    pf_top = longint'(py) - ps;
    bot    = longint'(by) + bs;
    lim    = pf_top + TOL;
    land   = hxp && (bot <= lim);
    side   = hxp && (bot > lim) && (longint'(by) - bs < longint'(py) + ps);
    hit    = sp_hit || side;
    alive  = (since >= LIVE);
    m_floor = GY;
    if (alive && hit) begin
      since = 0;
      if (m_att < 255) m_att++;
    end else begin
      if (since < 1000) since++;
      if (alive && land) m_floor = (pf_top < 0) ? 0 : (pf_top > GY) ? GY : int'(pf_top);
    end
  endtask

  task automatic step();
    int exp_state;
    @(posedge frame_clk);
    model_edge();
    #1;
    exp_state = (since < DF) ? 1 : (since < LIVE) ? 2 : 0;
    chk("death_reset", death_reset, (since < DF) ? 1 : 0);
    chk("ball_floor", ball_floor, m_floor);
    chk("attempts", attempts, m_att);
    chk("play_state", play_state, exp_state);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic spike_away();
    sx = -500; sy = 446; ss = 32;
  endtask

  initial begin
    Reset = 1'b1;
    bx = 100; by = 465; bs = 15;
    sx = 200; sy = 446; ss = 32;
    px = 1000; py = 1000; ps = 10;
    step();
    chk("reset_attempts", attempts, 0);
    Reset = 1'b0;

    // No contact
    steps(20);
    chk("idle_floor", ball_floor, GY);

    // Spike hit, then clear the spike and let the respawn run out
    sx = 140;
    step();
    chk("spike_death", death_reset, 1);
    chk("spike_att", attempts, 1);
    spike_away();
    steps(3);
    chk("dead_last", death_reset, 1);
    step();
    chk("to_respawn", play_state, 2);
    steps(12);

    // Landing on a platform, then stepping off it sideways
    px = 100; py = 450; ps = 28;
    by = 405;
    steps(3);
    chk("land_floor", ball_floor, 422);
    bx = 200;
    steps(2);
    chk("off_pf_floor", ball_floor, GY);

    // Side hit coinciding with a spike overlap: one death
    bx = 100; by = 465;
    sx = 140; sy = 446;
    step();
    chk("side_death", death_reset, 1);
    spike_away(); px = 1000; py = 1000;
    steps(16);

    // Continuous spike contact: grace spaces the deaths
    sx = 140; sy = 446;
    steps(30);

    // Reset on the second DEAD frame
    spike_away();
    steps(15);
    sx = 140;
    steps(2);
    Reset = 1'b1;
    step();
    chk("mid_dead_state", play_state, 0);
    chk("mid_dead_dr", death_reset, 0);
    chk("mid_dead_att", attempts, 0);
    Reset = 1'b0;

    // Saturation: keep the spike on long enough for 260+ deaths
    steps(260 * (LIVE + 1) + 20);
    chk("att_saturated", attempts, 255);

    // Random frames with negative coordinates and occasional resets
    for (int i = 0; i < 600; i++) begin
      Reset = ($urandom_range(0, 59) == 0);
      bx = int'($urandom_range(0, 160)) - 80;
      by = int'($urandom_range(0, 160)) - 80;
      bs = int'($urandom_range(1, 30));
      sx = int'($urandom_range(0, 200)) - 100;
      sy = int'($urandom_range(0, 200)) - 100;
      ss = int'($urandom_range(1, 30));
      px = int'($urandom_range(0, 160)) - 80;
      py = int'($urandom_range(0, 700)) - 100;
      ps = int'($urandom_range(1, 60));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
